ethernet_parser: RTL and testbench
==================================

ETHERNET_PARSER -- requirements
Module: ethernet_parser

Interface
REQ-001 The module SHALL use one clock and a reset that is synchronous and active-high; the ports SHALL be named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 frame_valid  input  1  frame_data carries a valid byte this cycle; low means a gap, with no byte consumed and state held.
REQ-005 frame_data  input  8  frame byte, sent in wire order starting at the first destination MAC byte.
REQ-006 frame_last  input  1  qualified by frame_valid; marks the final byte of the frame.
REQ-007 src_ip  output  32  IPv4 source address; the byte at the lowest offset lands in bits [31:24].
REQ-008 dst_ip  output  32  IPv4 destination address, with the same byte ordering as src_ip.
REQ-009 ip_valid  output  1  one-cycle pulse when src_ip/dst_ip are newly updated.

Function
REQ-010 A byte SHALL be accepted on every rising clk edge where frame_valid=1; the byte offset counter SHALL start at 0 at frame start and increment per accepted byte, saturating at 63.
REQ-011 The FSM SHALL have the states IDLE, ETH_HDR, IP_HDR, DRAIN.
- IDLE -> ETH_HDR on the first accepted byte (offset 0).
- ETH_HDR -> IP_HDR after offset 13 if EtherType (offsets 12-13, big-endian) = 0x0800; otherwise -> DRAIN.
- IP_HDR -> DRAIN after offset 33.
- Any state -> IDLE on an accepted byte with frame_last=1 (that byte still processed first).
REQ-012 In IP_HDR, the byte at offset 14 SHALL be checked: upper nibble = 4 and lower nibble (IHL) >= 5; on failure -> DRAIN with no capture.
REQ-013 Offsets 26-29 SHALL be shifted into the src shadow register and offsets 30-33 into the dst shadow register; src_ip/dst_ip SHALL NOT change before commit.
REQ-014 Commit SHALL occur on the clk edge accepting offset 33: src_ip/dst_ip load the shadow values (offset 33 included) and ip_valid=1 for exactly the following cycle.
REQ-015 Latency SHALL be 1 cycle from the edge accepting offset 33 to ip_valid high with final addresses.
REQ-016 src_ip/dst_ip SHALL hold their last committed values until the next commit.
REQ-017 A frame ending (frame_last) before offset 33 SHALL produce no ip_valid, leave outputs unchanged and discard the shadow registers.
REQ-018 frame_last on offset 33 itself SHALL both commit and return to IDLE; a new frame may start the next cycle.
REQ-019 Gaps (frame_valid=0) SHALL be allowed anywhere, including between offsets 32 and 33, and SHALL not alter the result.
REQ-020 Bytes in DRAIN SHALL be ignored until frame_last.

Reset
REQ-021 While rst=1 the module SHALL set: state IDLE, counter 0, shadow registers 0, src_ip=0, dst_ip=0, ip_valid=0.
REQ-022 Reset SHALL take priority over frame_valid; reset mid-frame SHALL abandon the frame, and the next accepted byte SHALL be offset 0.

Configuration
REQ-023 Macro ETHERNET_PARSER_VLAN_EN: when defined, EtherType 0x8100 at offsets 12-13 SHALL skip a 4-byte 802.1Q tag; the real EtherType is then read at offsets 16-17 and all IP offsets shift by +4 (commit at offset 37).
REQ-024 Without ETHERNET_PARSER_VLAN_EN, 0x8100 SHALL be treated as non-IPv4 (DRAIN).

Structure
REQ-025 Package ethernet_parser_pkg SHALL hold: ETHERTYPE_IPV4=16'h0800, ETHERTYPE_VLAN=16'h8100, the offsets of EtherType, the IP version byte, the first source-IP byte and the first destination-IP byte, VLAN_TAG_LEN=4, and the FSM state enum.
REQ-026 The block SHALL be a single module with no sub-module.

Verification
REQ-027 Frame: dst MAC 01:23:45:67:89:AB, src MAC 12:34:56:78:9A:BC, type 08 00, 0x45, zeros to offset 25, src C0 A8 01 64, dst C0 A8 01 01, frame_last on offset 33 -> one ip_valid pulse; src_ip=C0A80164, dst_ip=C0A80101.
REQ-028 Same frame with frame_valid gaps of 1-3 cycles inserted randomly -> identical outputs, single pulse.
REQ-029 EtherType 0x86DD, or first IP byte 0x65 -> no ip_valid; outputs keep previous values.
REQ-030 Frame truncated with frame_last at offset 29, followed by a valid frame with src 0A000001 and dst 0A000002 -> no pulse for the first frame, then src_ip=0A000001 and dst_ip=0A000002.
REQ-031 rst asserted at offset 28, then a full frame -> only the second frame commits; all outputs are 0 during reset.
REQ-032 With ETHERNET_PARSER_VLAN_EN: type 81 00, tag 00 64, type 08 00, then the header above -> src_ip=C0A80164, with ip_valid after offset 37.

Source files
------------

// File: rtl/ethernet_parser_pkg.sv
// Shared constants, header offsets and FSM state type for the Ethernet/IPv4 address parser.
// Offsets are for an untagged frame. An 802.1Q tag moves the later ones up by VLAN_TAG_LEN.
package ethernet_parser_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;

  localparam logic [5:0] OFF_ETHERTYPE = 6'd12;
  localparam logic [5:0] OFF_IP_VER    = 6'd14;
  localparam logic [5:0] OFF_SRC_IP    = 6'd26;
  localparam logic [5:0] OFF_DST_IP    = 6'd30;
  localparam logic [5:0] VLAN_TAG_LEN  = 6'd4;
  localparam logic [5:0] OFF_MAX       = 6'd63;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ETH_HDR = 2'd1,
    IP_HDR  = 2'd2,
    DRAIN   = 2'd3
  } parser_state_e;

  // The first IPv4 byte holds the version and the IHL. IHL counts 32-bit words, so 5 is the minimum header.
  function automatic logic ipv4_hdr_ok(input logic [7:0] b);
    return (b[7:4] == 4'd4) && (b[3:0] >= 4'd5);
  endfunction

endpackage

// File: rtl/ethernet_parser_if.sv
// Byte-stream input and parsed IPv4 address output of ethernet_parser.
// The master drives frame bytes. The slave (the parser) returns the addresses.
interface ethernet_parser_if;

  logic        frame_valid;
  logic [7:0]  frame_data;
  logic        frame_last;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic        ip_valid;

  modport master (
    output frame_valid, frame_data, frame_last,
    input  src_ip, dst_ip, ip_valid
  );

  modport slave (
    input  frame_valid, frame_data, frame_last,
    output src_ip, dst_ip, ip_valid
  );

endinterface

// File: rtl/ethernet_parser.sv
// Extracts the IPv4 source and destination addresses from an Ethernet frame byte stream.
// Define ETHERNET_PARSER_VLAN_EN to skip one 802.1Q tag. When this macro is not defined, a 0x8100 EtherType is treated as non-IPv4.
//
// state   | meaning
// IDLE    | waiting for byte 0 of a frame
// ETH_HDR | MAC addresses and EtherType (plus the 802.1Q tag when that is enabled)
// IP_HDR  | IPv4 header: version check, then capture of the address bytes
// DRAIN   | ignore bytes until frame_last
module ethernet_parser
  import ethernet_parser_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  ethernet_parser_if.slave  bus
);

  parser_state_e state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [5:0]    shift_q, shift_d;
  logic [7:0]    etype_hi_q, etype_hi_d;
  logic [31:0]   src_sh_q, src_sh_d;
  logic [31:0]   dst_sh_q, dst_sh_d;
  logic [31:0]   src_ip_q, src_ip_d;
  logic [31:0]   dst_ip_q, dst_ip_d;
  logic          ip_valid_q, ip_valid_d;

  logic [15:0]   etype;
  logic [5:0]    etype_off, ver_off, src_off, dst_off, commit_off;

  assign etype      = {etype_hi_q, bus.frame_data};
  assign etype_off  = OFF_ETHERTYPE + shift_q;
  assign ver_off    = OFF_IP_VER + shift_q;
  assign src_off    = OFF_SRC_IP + shift_q;
  assign dst_off    = OFF_DST_IP + shift_q;
  assign commit_off = OFF_DST_IP + shift_q + 6'd3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      etype_hi_q <= '0;
      src_sh_q   <= '0;
      dst_sh_q   <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      ip_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      etype_hi_q <= etype_hi_d;
      src_sh_q   <= src_sh_d;
      dst_sh_q   <= dst_sh_d;
      src_ip_q   <= src_ip_d;
      dst_ip_q   <= dst_ip_d;
      ip_valid_q <= ip_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    etype_hi_d = etype_hi_q;
    src_sh_d   = src_sh_q;
    dst_sh_d   = dst_sh_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;
    ip_valid_d = 1'b0;

    if (bus.frame_valid) begin
      cnt_d = (cnt_q == OFF_MAX) ? cnt_q : cnt_q + 6'd1;

      unique case (state_q)
        IDLE: state_d = ETH_HDR;

        ETH_HDR: begin
          if (cnt_q == etype_off) begin
            etype_hi_d = bus.frame_data;
          end else if (cnt_q == etype_off + 6'd1) begin
            if (etype == ETHERTYPE_IPV4) begin
              state_d = IP_HDR;
`ifdef ETHERNET_PARSER_VLAN_EN
            // Only a single tag is skipped. A second 0x8100 is sent to DRAIN.
            end else if (etype == ETHERTYPE_VLAN && shift_q == '0) begin
              shift_d = VLAN_TAG_LEN;
`endif
            end else begin
              state_d = DRAIN;
            end
          end
        end

        IP_HDR: begin
          if (cnt_q == ver_off) begin
            if (!ipv4_hdr_ok(bus.frame_data)) state_d = DRAIN;
          end else if (cnt_q >= src_off && cnt_q < dst_off) begin
            src_sh_d = {src_sh_q[23:0], bus.frame_data};
          end else if (cnt_q >= dst_off && cnt_q <= commit_off) begin
            dst_sh_d = {dst_sh_q[23:0], bus.frame_data};
            if (cnt_q == commit_off) begin
              src_ip_d   = src_sh_q;
              dst_ip_d   = {dst_sh_q[23:0], bus.frame_data};
              ip_valid_d = 1'b1;
              state_d    = DRAIN;
            end
          end
        end

        DRAIN: ;

        default: state_d = IDLE;
      endcase

      // The last byte has already been processed above, so a commit on offset 33 still takes effect.
      if (bus.frame_last) begin
        state_d    = IDLE;
        cnt_d      = '0;
        shift_d    = '0;
        etype_hi_d = '0;
        src_sh_d   = '0;
        dst_sh_d   = '0;
      end
    end
  end

  assign bus.src_ip   = src_ip_q;
  assign bus.dst_ip   = dst_ip_q;
  assign bus.ip_valid = ip_valid_q;

endmodule

// File: tb/tb_ethernet_parser.sv
// Directed bench for ethernet_parser. Each expected commit is queued when its frame is driven and checked against the ip_valid pulse it should cause.
module tb_ethernet_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_applied = 1'b1;

  int tests = 0;
  int fails = 0;

  logic [63:0] sb[$];
  logic [7:0]  fr[$];
  logic [31:0] exp_src = '0;
  logic [31:0] exp_dst = '0;

  ethernet_parser_if bus ();

  ethernet_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_applied <= rst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_applied) begin
      exp_src = '0;
      exp_dst = '0;
      check("reset_src_ip", bus.src_ip, 32'h0);
      check("reset_dst_ip", bus.dst_ip, 32'h0);
      check("reset_ip_valid", {31'b0, bus.ip_valid}, 32'h0);
    end else if (bus.ip_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", {31'b0, bus.ip_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        exp_src = e[63:32];
        exp_dst = e[31:0];
        check("commit_src_ip", bus.src_ip, exp_src);
        check("commit_dst_ip", bus.dst_ip, exp_dst);
      end
    end else begin
      check("hold_src_ip", bus.src_ip, exp_src);
      check("hold_dst_ip", bus.dst_ip, exp_dst);
      check("ip_valid_low", {31'b0, bus.ip_valid}, 32'h0);
    end
  end

  task automatic make_frame(input logic [15:0] et, input logic [7:0] ver,
                            input logic [31:0] s, input logic [31:0] d, input int len);
    logic [47:0] dmac;
    logic [47:0] smac;
    dmac = 48'h0123_4567_89AB;
    smac = 48'h1234_5678_9ABC;
    fr.delete();
    for (int i = 5; i >= 0; i--) fr.push_back(dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) fr.push_back(smac[i*8 +: 8]);
    fr.push_back(et[15:8]);
    fr.push_back(et[7:0]);
    fr.push_back(ver);
    while (fr.size() < 26) fr.push_back(8'h00);
    for (int i = 3; i >= 0; i--) fr.push_back(s[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fr.push_back(d[i*8 +: 8]);
    while (fr.size() < len) fr.push_back(8'hEE);
  endtask

  // Drives fr[0..nbytes-1] and raises frame_last on the final byte if use_last is set.
  // A non-zero max_gap inserts random idle gaps and always puts one in front of the commit byte.
  task automatic send_frame(input int nbytes, input bit use_last, input int max_gap,
                            input bit commit, input int commit_off, input logic [63:0] exp);
    int g;
    if (commit) sb.push_back(exp);
    for (int i = 0; i < nbytes; i++) begin
      if (max_gap > 0 && (i == commit_off || $urandom_range(0, 1) == 1)) begin
        g = $urandom_range(1, max_gap);
        bus.frame_valid = 1'b0;
        bus.frame_last  = 1'b0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      bus.frame_valid = 1'b1;
      bus.frame_data  = fr[i];
      bus.frame_last  = use_last && (i == nbytes - 1);
      @(posedge clk);
      #1;
      if (commit && i == commit_off)
        check("latency_pulse", {31'b0, bus.ip_valid}, 32'h1);
    end
    bus.frame_valid = 1'b0;
    bus.frame_last  = 1'b0;
  endtask

  initial begin
    bus.frame_valid = 1'b0;
    bus.frame_data  = 8'h00;
    bus.frame_last  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    make_frame(16'h0800, 8'h45, 32'hC0A8_0164, 32'hC0A8_0101, 34);
    send_frame(34, 1'b1, 0, 1'b1, 33, {32'hC0A8_0164, 32'hC0A8_0101});
    repeat (2) @(posedge clk);
    #1;

    send_frame(34, 1'b1, 3, 1'b1, 33, {32'hC0A8_0164, 32'hC0A8_0101});

    make_frame(16'h86DD, 8'h45, 32'h1111_1111, 32'h2222_2222, 34);
    send_frame(34, 1'b1, 0, 1'b0, 33, '0);
    make_frame(16'h0800, 8'h65, 32'h1111_1111, 32'h2222_2222, 34);
    send_frame(34, 1'b1, 0, 1'b0, 33, '0);
    make_frame(16'h0800, 8'h44, 32'h1111_1111, 32'h2222_2222, 34);
    send_frame(34, 1'b1, 0, 1'b0, 33, '0);

    make_frame(16'h0800, 8'h45, 32'h3333_3333, 32'h4444_4444, 34);
    send_frame(30, 1'b1, 0, 1'b0, 33, '0);
    make_frame(16'h0800, 8'h45, 32'h0A00_0001, 32'h0A00_0002, 34);
    send_frame(34, 1'b1, 0, 1'b1, 33, {32'h0A00_0001, 32'h0A00_0002});

    make_frame(16'h0800, 8'h45, 32'hC0A8_0164, 32'hC0A8_0101, 34);
    fr.insert(12, 8'h81);
    fr.insert(13, 8'h00);
    fr.insert(14, 8'h00);
    fr.insert(15, 8'h64);
`ifdef ETHERNET_PARSER_VLAN_EN
    send_frame(38, 1'b1, 0, 1'b1, 37, {32'hC0A8_0164, 32'hC0A8_0101});
`else
    send_frame(38, 1'b1, 0, 1'b0, 37, '0);
`endif

    // A frame that runs past offset 63, followed at once by another frame with no idle cycle between them.
    make_frame(16'h0800, 8'h46, 32'hAABB_CCDD, 32'h0102_0304, 70);
    send_frame(70, 1'b1, 0, 1'b1, 33, {32'hAABB_CCDD, 32'h0102_0304});
    make_frame(16'h0800, 8'h4F, 32'h0A00_0001, 32'h0A00_0002, 34);
    send_frame(34, 1'b1, 0, 1'b1, 33, {32'h0A00_0001, 32'h0A00_0002});

    make_frame(16'h0800, 8'h45, 32'h5555_5555, 32'h6666_6666, 34);
    send_frame(28, 1'b0, 0, 1'b0, 33, '0);
    bus.frame_valid = 1'b1;
    bus.frame_data  = fr[28];
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    make_frame(16'h0800, 8'h45, 32'h0A00_0003, 32'h0A00_0004, 34);
    send_frame(34, 1'b1, 0, 1'b1, 33, {32'h0A00_0003, 32'h0A00_0004});

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
